// File: rtl/mem_lsu_pkg.sv
// Shared types and opcodes for the MIPS memory-access stage (mem_lsu).
// The bus request is built here so the top stays a thin FSM.
package mem_lsu_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;
  localparam int BYTE_EN_BUS  = 4;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic [ALU_OP_BUS-1:0] ALU_OP_NOP  = 8'h00;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_ADDU = 8'h21;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_LB   = 8'he0;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_LH   = 8'he1;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_LW   = 8'he3;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_SB   = 8'he8;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_SH   = 8'he9;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_SW   = 8'heb;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                   we;
    logic [REG_BUS-1:0]     addr;
    logic [BYTE_EN_BUS-1:0] be;
    logic [REG_BUS-1:0]     wdata;
  } dbus_req_t;

  function automatic logic is_load(input logic [ALU_OP_BUS-1:0] op);
    return (op == ALU_OP_LB) || (op == ALU_OP_LH) || (op == ALU_OP_LW);
  endfunction

  function automatic logic is_mem_op(input logic [ALU_OP_BUS-1:0] op);
    return is_load(op) || (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
  endfunction

  // Little-endian lane placement; the bus only ever sees word addresses.
  function automatic dbus_req_t build_req(input logic [ALU_OP_BUS-1:0] op,
                                          input logic [REG_BUS-1:0]    addr,
                                          input logic [REG_BUS-1:0]    reg2);
    dbus_req_t r;
    r.we    = 1'b0;
    r.addr  = {addr[REG_BUS-1:2], 2'b00};
    r.be    = 4'b1111;
    r.wdata = ZERO_WORD;
    case (op)
      ALU_OP_SW: begin
        r.we    = 1'b1;
        r.wdata = reg2;
      end
      ALU_OP_SH: begin
        r.we    = 1'b1;
        r.be    = addr[1] ? 4'b1100 : 4'b0011;
        r.wdata = {2{reg2[15:0]}};
      end
      ALU_OP_SB: begin
        r.we    = 1'b1;
        r.be    = 4'b0001 << addr[1:0];
        r.wdata = {4{reg2[7:0]}};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Combinational load formatter: picks the addressed lane of a bus word and
// sign-extends it for LH/LB; LW and anything else pass the word through.
module mem_load_align
  import mem_lsu_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] aluop,
  input  logic [1:0]            addr,
  input  logic [REG_BUS-1:0]    rdata,
  output logic [REG_BUS-1:0]    result
);

  logic [15:0] half;
  logic [7:0]  lane;

  assign half = addr[1] ? rdata[31:16] : rdata[15:0];
  assign lane = rdata[{addr, 3'b000} +: 8];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = rdata;
    case (aluop)
      ALU_OP_LH: result = {{16{half[15]}}, half};
      ALU_OP_LB: result = {{24{lane[7]}}, lane};
      default:   ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MIPS memory-access stage: pass-through for ALU ops, IDLE/BUSY/DONE FSM over a
// req/ack data bus for loads and stores. Optional: MEM_ALIGN_CHECK_EN.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_BUS-1:0]   aluop_i,
  input  logic [REG_ADDR_BUS-1:0] wd_i,
  input  logic                    wreg_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  input  logic [REG_BUS-1:0]      mem_addr_i,
  input  logic [REG_BUS-1:0]      reg2_i,
  output logic [REG_ADDR_BUS-1:0] wd_o,
  output logic                    wreg_o,
  output logic [REG_BUS-1:0]      wdata_o,
  output logic                    stallreq_o,
  output logic                    dbus_req_o,
  output logic                    dbus_we_o,
  output logic [REG_BUS-1:0]      dbus_addr_o,
  output logic [BYTE_EN_BUS-1:0]  dbus_be_o,
  output logic [REG_BUS-1:0]      dbus_wdata_o,
  input  logic [REG_BUS-1:0]      dbus_rdata_i,
  input  logic                    dbus_ack_i,
  output logic                    align_err_o
);

  mem_state_e            state;
  dbus_req_t             req_q;
  logic [ALU_OP_BUS-1:0] op_q;
  logic [1:0]            off_q;
  logic [REG_BUS-1:0]    rdata_q;
  logic [REG_BUS-1:0]    load_data;
  logic                  mem_op;
  logic                  misalign;
  logic                  start;

  assign mem_op = is_mem_op(aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((aluop_i == ALU_OP_LW) && (mem_addr_i[1:0] != 2'b00)) ||
                    ((aluop_i == ALU_OP_LH) && mem_addr_i[0]);
  // Gated by rst so the pulse obeys the all-zero reset view of the outputs.
  assign align_err_o = !rst && (state == MEM_ST_IDLE) && mem_op && misalign;
`else
  assign misalign    = 1'b0;
  assign align_err_o = 1'b0;
`endif

  assign start = (state == MEM_ST_IDLE) && mem_op && !misalign;

  // Formatting uses the latched op and offset, not the live inputs.
  mem_load_align u_load_align (
    .aluop  (op_q),
    .addr   (off_q),
    .rdata  (dbus_rdata_i),
    .result (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_ST_IDLE;
      req_q      <= '0;
      op_q       <= '0;
      off_q      <= '0;
      rdata_q    <= ZERO_WORD;
      dbus_req_o <= 1'b0;
    end else begin
      case (state)
        MEM_ST_IDLE: begin
          if (start) begin
            req_q      <= build_req(aluop_i, mem_addr_i, reg2_i);
            op_q       <= aluop_i;
            off_q      <= mem_addr_i[1:0];
            dbus_req_o <= 1'b1;
            state      <= MEM_ST_BUSY;
          end
        end
        MEM_ST_BUSY: begin
          if (dbus_ack_i) begin
            if (!req_q.we) rdata_q <= load_data;
            dbus_req_o <= 1'b0;
            state      <= MEM_ST_DONE;
          end
        end
        MEM_ST_DONE: state <= MEM_ST_IDLE;
        default:     state <= MEM_ST_IDLE;
      endcase
    end
  end

  assign dbus_we_o    = req_q.we;
  assign dbus_addr_o  = req_q.addr;
  assign dbus_be_o    = req_q.be;
  assign dbus_wdata_o = req_q.wdata;

  // Stall is combinational so the op is held in EX/MEM in the very cycle it arrives.
  assign stallreq_o = !rst && (start || (state == MEM_ST_BUSY));
  assign wd_o       = wd_i;

  always_comb begin
    wreg_o  = wreg_i;
    wdata_o = wdata_i;
    case (state)
      MEM_ST_IDLE: if (mem_op) wreg_o = 1'b0;
      MEM_ST_BUSY: wreg_o = 1'b0;
      MEM_ST_DONE: begin
        if (is_load(op_q)) wdata_o = rdata_q;
        else               wreg_o  = 1'b0;
      end
      default: wreg_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: transaction table plus reset and alignment
// sequences. Covers MEM_ALIGN_CHECK_EN in either build.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, mem_addr_i, reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o, dbus_rdata_i;
  logic        dbus_ack_i, align_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .aluop_i      (aluop_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stallreq_o   (stallreq_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_ack_i   (dbus_ack_i),
    .align_err_o  (align_err_o)
  );

  typedef struct {
    bit          mem;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_bus_wdata;
    logic [31:0] e_wdata;
    logic        e_wreg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit mem, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] wdata,
                              input logic [4:0] wd, input logic [31:0] rdata, input int waits,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic e_we, input logic [31:0] e_bus_wdata,
                              input logic [31:0] e_wdata, input logic e_wreg);
    vec_t v;
    v.mem = mem; v.aluop = op; v.addr = addr; v.reg2 = reg2; v.wdata = wdata; v.wd = wd;
    v.rdata = rdata; v.waits = waits; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
    v.e_bus_wdata = e_bus_wdata; v.e_wdata = e_wdata; v.e_wreg = e_wreg;
    return v;
  endfunction

  task automatic idle_inputs();
    aluop_i = ALU_OP_NOP; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    mem_addr_i = 32'h0; reg2_i = 32'h0;
  endtask

  // Drives one op, plays the bus slave with v.waits wait states, checks every phase.
  task automatic run_vec(input vec_t v);
    int stalls = 0;
    int busy_n = 0;
    @(posedge clk); #1;
    aluop_i = v.aluop; mem_addr_i = v.addr; reg2_i = v.reg2;
    wdata_i = v.wdata; wd_i = v.wd; wreg_i = 1'b1;
    @(negedge clk);
    if (!v.mem) begin
      check("pass_wdata", wdata_o, v.e_wdata);
      check("pass_wd", {27'd0, wd_o}, {27'd0, v.wd});
      check("pass_wreg", {31'd0, wreg_o}, {31'd0, v.e_wreg});
      check("pass_stall", {31'd0, stallreq_o}, 32'd0);
      check("pass_req", {31'd0, dbus_req_o}, 32'd0);
    end else begin
      while (stallreq_o && stalls < 20) begin
        stalls++;
        check("stall_wreg", {31'd0, wreg_o}, 32'd0);
        if (dbus_req_o) begin
          if (busy_n == 0) begin
            check("bus_addr", dbus_addr_o, v.e_addr);
            check("bus_be", {28'd0, dbus_be_o}, {28'd0, v.e_be});
            check("bus_we", {31'd0, dbus_we_o}, {31'd0, v.e_we});
            if (v.e_we) check("bus_wdata", dbus_wdata_o, v.e_bus_wdata);
          end
          dbus_ack_i   = (busy_n == v.waits);
          dbus_rdata_i = dbus_ack_i ? v.rdata : 32'h0BAD_F00D;
          busy_n++;
        end
        @(negedge clk);
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h5A5A_5A5A;
      end
      check("stall_cycles", stalls, v.waits + 2);
      check("done_req", {31'd0, dbus_req_o}, 32'd0);
      check("done_wreg", {31'd0, wreg_o}, {31'd0, v.e_wreg});
      if (!v.e_we) check("done_wdata", wdata_o, v.e_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    dbus_ack_i = 1'b0;
    dbus_rdata_i = 32'h0;
    idle_inputs();
    aluop_i = ALU_OP_ADDU; wdata_i = 32'h77; wd_i = 5'd9; wreg_i = 1'b1;

    //          mem op          addr          reg2          wdata    wd   rdata         w  e_addr        be       we    bus_wdata     e_wdata       wreg
    vecs.push_back(mk(0, ALU_OP_ADDU, 32'h0,        32'h0,        32'h5,   5'd3, 32'h0,        0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_0005, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LW,   32'h0000_0100, 32'h0,        32'h0,   5'd4, 32'hDEAD_BEEF, 2, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LB,   32'h0000_0103, 32'h0,        32'h0,   5'd5, 32'h80FF_1234, 0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LH,   32'h0000_0102, 32'h0,        32'h0,   5'd6, 32'h80FF_1234, 0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hFFFF_80FF, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LH,   32'h0000_0100, 32'h0,        32'h0,   5'd6, 32'h80FF_7234, 1, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'h0000_7234, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LB,   32'h0000_0101, 32'h0,        32'h0,   5'd7, 32'h80FF_1234, 0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'h0000_0012, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LB,   32'h0000_0102, 32'h0,        32'h0,   5'd7, 32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(1, ALU_OP_SH,   32'h0000_0102, 32'h0000_ABCD, 32'h0,   5'd8, 32'h0,        0, 32'h0000_0100, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0,        1'b0));
    vecs.push_back(mk(1, ALU_OP_SH,   32'h0000_0200, 32'h1234_ABCD, 32'h0,   5'd8, 32'h0,        1, 32'h0000_0200, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h0,        1'b0));
    vecs.push_back(mk(1, ALU_OP_SB,   32'h0000_0305, 32'h1122_3344, 32'h0,   5'd8, 32'h0,        0, 32'h0000_0304, 4'b0010, 1'b1, 32'h4444_4444, 32'h0,        1'b0));
    vecs.push_back(mk(1, ALU_OP_SB,   32'h0000_0307, 32'h1122_33A5, 32'h0,   5'd8, 32'h0,        2, 32'h0000_0304, 4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0,        1'b0));
    vecs.push_back(mk(1, ALU_OP_SW,   32'h0000_0400, 32'hCAFE_F00D, 32'h0,   5'd8, 32'h0,        3, 32'h0000_0400, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0,        1'b0));
    vecs.push_back(mk(0, ALU_OP_ADDU, 32'h0,        32'h0,        32'h1234, 5'd7, 32'h0,        0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_1234, 1'b1));
    vecs.push_back(mk(1, ALU_OP_LW,   32'h0000_0104, 32'h0,        32'h0,   5'd2, 32'h0123_4567, 1, 32'h0000_0104, 4'b1111, 1'b0, 32'h0,        32'h0123_4567, 1'b1));

    // Reset view: bus quiet, pass-through live.
    #2;
    check("rst_req", {31'd0, dbus_req_o}, 32'd0);
    check("rst_addr", dbus_addr_o, 32'h0);
    check("rst_be", {28'd0, dbus_be_o}, 32'd0);
    check("rst_align", {31'd0, align_err_o}, 32'd0);
    check("rst_pass_wdata", wdata_o, 32'h77);
    check("rst_pass_wd", {27'd0, wd_o}, 32'd9);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while BUSY abandons the transaction immediately.
    @(posedge clk); #1;
    aluop_i = ALU_OP_SW; mem_addr_i = 32'h10; reg2_i = 32'h1; wreg_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midbusy_req_before", {31'd0, dbus_req_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midbusy_req_after", {31'd0, dbus_req_o}, 32'd0);
    check("midbusy_stall", {31'd0, stallreq_o}, 32'd0);
    check("midbusy_we", {31'd0, dbus_we_o}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", {31'd0, dbus_req_o}, 32'd0);
    check("post_rst_stall", {31'd0, stallreq_o}, 32'd0);
    run_vec(vecs[2]);

    // Misaligned LW: flagged and dropped with the check built in, plain access otherwise.
`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    aluop_i = ALU_OP_LW; mem_addr_i = 32'h0000_0101; wreg_i = 1'b1; wd_i = 5'd4;
    @(negedge clk);
    check("align_err", {31'd0, align_err_o}, 32'd1);
    check("align_req", {31'd0, dbus_req_o}, 32'd0);
    check("align_stall", {31'd0, stallreq_o}, 32'd0);
    check("align_wreg", {31'd0, wreg_o}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("align_err_pulse", {31'd0, align_err_o}, 32'd0);
    check("align_stay_idle", {31'd0, dbus_req_o}, 32'd0);
`else
    @(posedge clk); #1;
    aluop_i = ALU_OP_LW; mem_addr_i = 32'h0000_0101; wreg_i = 1'b1;
    #1;
    check("noalign_err", {31'd0, align_err_o}, 32'd0);
    idle_inputs();
    run_vec(mk(1, ALU_OP_LW, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 32'h1357_9BDF, 0,
               32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF, 1'b1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
